// File: rtl/texture_mapper_divider_seq.sv
// Iterative restoring divider for the texture-mapper datapath.
// Retires bits_per_cycle quotient bits per clock, with signed or unsigned
// operation chosen per transaction. Divide-by-zero and signed overflow
// produce fixed, flagged results through the same state sequence.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid never depends on ready, and the data on a channel is stable
// while valid is high and ready is low.
module texture_mapper_divider_seq #(
    parameter int width_n        = 32,
    parameter int width_d        = 32,
    parameter int bits_per_cycle = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [width_n-1:0] numer,
    input  logic [width_d-1:0] denom,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [width_n-1:0] quotient,
    output logic [width_d-1:0] remain,
    output logic               div_by_zero,
    output logic               overflow,
    output logic [2:0]         dbg_state
);

    localparam int N     = width_n / bits_per_cycle;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [width_n-1:0] MOST_NEG = {1'b1, {(width_n-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic [width_n-1:0] numer_q, numer_d;
    logic [width_d-1:0] denom_q, denom_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [width_n-1:0] dmag_q, dmag_d;
    logic [width_n-1:0] acc_q, acc_d;     // numerator magnitude shifting out, quotient shifting in
    logic [width_n-1:0] part_q, part_d;   // partial remainder, always below dmag_q
    logic [width_n-1:0] quotient_q, quotient_d;
    logic [width_d-1:0] remain_q, remain_d;
    logic               dz_q, dz_d;
    logic               ov_q, ov_d;

    // Operand magnitudes and sign bookkeeping used in PREP
    logic               n_neg, d_neg;
    logic [width_n-1:0] n_mag, d_ext, d_mag;
    // One iteration's worth of restoring steps
    logic [width_n:0]   trial;
    logic [width_n-1:0] step_part, step_acc;
    // Result selection used in FIXUP
    logic               is_dz, is_ov;
    logic [width_d-1:0] rem_mag;

    // Magnitudes of the captured operands; denom is sign-extended in signed mode
    always_comb begin
        n_neg = sgn_q & numer_q[width_n-1];
        d_neg = sgn_q & denom_q[width_d-1];
        n_mag = n_neg ? ('0 - numer_q) : numer_q;
        d_ext = {width_n{d_neg}};
        d_ext[width_d-1:0] = denom_q;
        d_mag = d_neg ? ('0 - d_ext) : d_ext;
    end

    // Unrolled restoring shift-subtract for bits_per_cycle quotient bits
    always_comb begin
        step_part = part_q;
        step_acc  = acc_q;
        trial     = '0;
        for (int i = 0; i < bits_per_cycle; i++) begin
            trial    = {step_part, step_acc[width_n-1]};
            step_acc = {step_acc[width_n-2:0], 1'b0};
            if (trial >= {1'b0, dmag_q}) begin
                trial       = trial - {1'b0, dmag_q};
                step_acc[0] = 1'b1;
            end
            step_part = trial[width_n-1:0];
        end
    end

    // Special-case detection on the captured operands
    always_comb begin
        is_dz   = (denom_q == '0);
        is_ov   = sgn_q && (numer_q == MOST_NEG) && (denom_q == '1);
        rem_mag = part_q[width_d-1:0];
    end

    // Next-state and datapath update for the divider sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sgn_d      = sgn_q;
        numer_d    = numer_q;
        denom_d    = denom_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        dmag_d     = dmag_q;
        acc_d      = acc_q;
        part_d     = part_q;
        quotient_d = quotient_q;
        remain_d   = remain_q;
        dz_d       = dz_q;
        ov_d       = ov_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sgn_d   = in_signed;
                    numer_d = numer;
                    denom_d = denom;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                qneg_d  = n_neg ^ d_neg;
                rneg_d  = n_neg;
                dmag_d  = d_mag;
                acc_d   = n_mag;
                part_d  = '0;
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                acc_d  = step_acc;
                part_d = step_part;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (is_dz) begin
                    quotient_d = '1;
                    remain_d   = numer_q[width_d-1:0];
                    dz_d       = 1'b1;
                    ov_d       = 1'b0;
                end else if (is_ov) begin
                    quotient_d = numer_q;
                    remain_d   = '0;
                    dz_d       = 1'b0;
                    ov_d       = 1'b1;
                end else begin
                    quotient_d = qneg_q ? ('0 - acc_q) : acc_q;
                    remain_d   = rneg_q ? ('0 - rem_mag) : rem_mag;
                    dz_d       = 1'b0;
                    ov_d       = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset discards any operation in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sgn_q      <= 1'b0;
            numer_q    <= '0;
            denom_q    <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dmag_q     <= '0;
            acc_q      <= '0;
            part_q     <= '0;
            quotient_q <= '0;
            remain_q   <= '0;
            dz_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sgn_q      <= sgn_d;
            numer_q    <= numer_d;
            denom_q    <= denom_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            dmag_q     <= dmag_d;
            acc_q      <= acc_d;
            part_q     <= part_d;
            quotient_q <= quotient_d;
            remain_q   <= remain_d;
            dz_q       <= dz_d;
            ov_q       <= ov_d;
        end
    end

    // Handshake flags follow the state register and read 0 while reset is held
    assign in_ready    = (state_q == S_IDLE) && !reset;
    assign out_valid   = (state_q == S_DONE) && !reset;
    assign quotient    = quotient_q;
    assign remain      = remain_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_texture_mapper_divider_seq.sv
// Bench for texture_mapper_divider_seq: directed vector table on a 32/32/1
// instance, hand-written backpressure and mid-operation reset sequences, and
// a randomized sweep on a 16/8/4 instance against an arithmetic model.
module tb_texture_mapper_divider_seq;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // 32/32/1 instance
  logic        in_valid = 1'b0, in_ready, in_signed = 1'b0;
  logic [31:0] numer = '0, denom = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] quotient, remain;
  logic        div_by_zero, overflow;
  logic [2:0]  dbg_state;

  texture_mapper_divider_seq #(.width_n(32), .width_d(32), .bits_per_cycle(1)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .numer(numer), .denom(denom),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remain(remain),
    .div_by_zero(div_by_zero), .overflow(overflow), .dbg_state(dbg_state)
  );

  // 16/8/4 instance
  logic        s_in_valid = 1'b0, s_in_ready, s_in_signed = 1'b0;
  logic [15:0] s_numer = '0;
  logic [7:0]  s_denom = '0;
  logic        s_out_valid, s_out_ready = 1'b0;
  logic [15:0] s_quotient;
  logic [7:0]  s_remain;
  logic        s_div_by_zero, s_overflow;
  logic [2:0]  s_dbg_state;

  texture_mapper_divider_seq #(.width_n(16), .width_d(8), .bits_per_cycle(4)) dut_s (
    .clock(clock), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_signed(s_in_signed),
    .numer(s_numer), .denom(s_denom),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .quotient(s_quotient), .remain(s_remain),
    .div_by_zero(s_div_by_zero), .overflow(s_overflow), .dbg_state(s_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (32-bit instance) ----------------
  task automatic a_start(input logic sgn, input logic [31:0] n, input logic [31:0] d);
    int t;
    @(negedge clock);
    in_valid  = 1'b1;
    in_signed = sgn;
    numer     = n;
    denom     = d;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clock);
    @(negedge clock);
    // Scramble inputs after the accept; they must have no effect
    in_valid  = 1'b0;
    in_signed = ~sgn;
    numer     = $urandom();
    denom     = $urandom();
  endtask

  // Called in the cycle right after the accept edge; counts cycles until out_valid
  task automatic a_wait(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic a_finish();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  // ---------------- reference model (16/8) ----------------
  task automatic model16(input logic sgn, input logic [15:0] n, input logic [7:0] d,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic dz, output logic ov);
    int ni, di, qi, ri;
    dz = 1'b0;
    ov = 1'b0;
    if (d == 8'h00) begin
      q  = 16'hFFFF;
      r  = n[7:0];
      dz = 1'b1;
    end else if (sgn && n == 16'h8000 && d == 8'hFF) begin
      q  = 16'h8000;
      r  = 8'h00;
      ov = 1'b1;
    end else if (sgn) begin
      ni = int'($signed(n));
      di = int'($signed(d));
      qi = ni / di;
      ri = ni % di;
      q  = 16'(qi);
      r  = 8'(ri);
    end else begin
      q = n / {8'h00, d};
      r = 8'(n % {8'h00, d});
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sgn;
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat;
    int stall;
    logic seen;
    logic [31:0] hold_q, hold_r;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'd0,          32'd3,          32'd0,          32'd0,          1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 1'b0};

    // ---------------- reset state ----------------
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remain", remain, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_ov", overflow, 0);
    check("rst_s_in_ready", s_in_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_release_in_ready", in_ready, 1);
    check("rst_release_state", dbg_state, 0);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(vecs[i].q);
      a_start(vecs[i].sgn, vecs[i].n, vecs[i].d);
      a_wait(lat);
      check($sformatf("v%0d_latency", i), lat, 35);
      check($sformatf("v%0d_quotient", i), quotient, exp_q.pop_front());
      check($sformatf("v%0d_remain", i), remain, vecs[i].r);
      check($sformatf("v%0d_dz", i), div_by_zero, vecs[i].dz);
      check($sformatf("v%0d_ov", i), overflow, vecs[i].ov);
      a_finish();
      check($sformatf("v%0d_in_ready_after", i), in_ready, 1);
      check($sformatf("v%0d_quotient_hold", i), quotient, vecs[i].q);
    end

    // ---------------- backpressure ----------------
    a_start(1'b0, 32'd1000, 32'd7);
    a_wait(lat);
    check("bp_latency", lat, 35);
    hold_q = 32'd142;
    hold_r = 32'd6;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_valid_%0d", c), out_valid, 1);
      check($sformatf("bp_in_ready_%0d", c), in_ready, 0);
      check($sformatf("bp_quotient_%0d", c), quotient, hold_q);
      check($sformatf("bp_remain_%0d", c), remain, hold_r);
      @(negedge clock);
    end
    a_finish();
    check("bp_in_ready_next", in_ready, 1);
    check("bp_valid_drop", out_valid, 0);
    a_start(1'b0, 32'd1000, 32'd10);
    a_wait(lat);
    check("bp2_latency", lat, 35);
    check("bp2_quotient", quotient, 100);
    check("bp2_remain", remain, 0);
    a_finish();

    // ---------------- reset during ITER ----------------
    a_start(1'b1, 32'hFFFF0000, 32'd3);
    repeat (10) @(negedge clock);
    check("mr_in_iter", dbg_state, 2);
    reset = 1'b1;
    #1;
    check("mr_in_ready_during", in_ready, 0);
    @(negedge clock);
    check("mr_state_idle", dbg_state, 0);
    check("mr_quotient", quotient, 0);
    check("mr_remain", remain, 0);
    check("mr_out_valid", out_valid, 0);
    reset = 1'b0;
    #1;
    check("mr_in_ready_after", in_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    check("mr_no_valid_pulse", seen, 0);
    a_start(1'b0, 32'd9, 32'd4);
    a_wait(lat);
    check("mr2_latency", lat, 35);
    check("mr2_quotient", quotient, 2);
    check("mr2_remain", remain, 1);
    a_finish();

    // ---------------- randomized sweep on 16/8/4 ----------------
    for (int k = 0; k < 300; k++) begin
      logic        sg;
      logic [15:0] n, eq;
      logic [7:0]  d, er;
      logic        edz, eov;
      int          t;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       n = 16'h8000;
        1:       n = 16'h0000;
        2:       n = 16'hFFFF;
        default: n = 16'($urandom());
      endcase
      case ($urandom_range(0, 7))
        0:       d = 8'h00;
        1:       d = 8'hFF;
        2:       d = 8'h01;
        3:       d = 8'h80;
        default: d = 8'($urandom());
      endcase
      model16(sg, n, d, eq, er, edz, eov);
      @(negedge clock);
      s_in_valid  = 1'b1;
      s_in_signed = sg;
      s_numer     = n;
      s_denom     = d;
      t = 0;
      while (!s_in_ready && t < 50) begin
        @(negedge clock);
        t++;
      end
      @(posedge clock);
      @(negedge clock);
      s_in_valid  = 1'b0;
      s_in_signed = ~sg;
      s_numer     = 16'($urandom());
      s_denom     = 8'($urandom());
      lat = 1;
      while (!s_out_valid && lat < 50) begin
        @(negedge clock);
        lat++;
      end
      check($sformatf("sw%0d_latency", k), lat, 7);
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clock);
      check($sformatf("sw%0d_valid_held", k), s_out_valid, 1);
      check($sformatf("sw%0d_quotient", k), s_quotient, eq);
      check($sformatf("sw%0d_remain", k), s_remain, er);
      check($sformatf("sw%0d_dz", k), s_div_by_zero, edz);
      check($sformatf("sw%0d_ov", k), s_overflow, eov);
      s_out_ready = 1'b1;
      @(negedge clock);
      s_out_ready = 1'b0;
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
